ddr3_port_arbiter: RTL and testbench

Shares the single CPU-side command port of the DDR3 controller between NUM_REQ requesters, such as multiple CPU models or a CPU plus a test/DMA agent. It uses round-robin arbitration with a valid/ready handshake on both sides. Accepted reads have their requester IDs tracked in an in-order ID FIFO, so the controller's read-data returns are routed back to the requester that issued them. The block sits between the CPU-side interface and the controller inside the top level, on i_cpu_ck.

---
 rtl/ddr3_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_port_arbiter
// Purpose  : Round-robin sharing of the DDR3 controller command port between
//            NUM_REQ requesters, with in-order read-return routing.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                          i_cpu_ck,
    input  logic                          i_cpu_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rd_valid,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_ctrl_valid,
    output logic                          o_ctrl_we,
    output logic [ADDR_W-1:0]             o_ctrl_addr,
    output logic [DATA_W-1:0]             o_ctrl_wdata,
    input  logic                          i_ctrl_ready,
    input  logic                          i_ctrl_rd_valid,
    input  logic [DATA_W-1:0]             i_ctrl_rd_data,
    output logic [$clog2(MAX_OUT):0]      o_outstanding,
    output logic                          o_err
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1   = ID_W + 1;
    localparam int FP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_win_id;
    logic                r_ctrl_valid;
    logic                r_ctrl_we;
    logic [ADDR_W-1:0]   r_ctrl_addr;
    logic [DATA_W-1:0]   r_ctrl_wdata;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [NUM_REQ-1:0]  r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_err;
    logic [CNT_W-1:0]    r_count;
    logic [FP_W-1:0]     r_wptr;
    logic [FP_W-1:0]     r_rptr;
    logic [ID_W-1:0]     r_fifo [MAX_OUT];

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_rd_room;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [IW1-1:0]      w_idx;
    logic [ID_W-1:0]     w_rr_next;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_spurious;
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign w_addr_arr[k]  = i_req_addr[k*ADDR_W +: ADDR_W];
            assign w_wdata_arr[k] = i_req_wdata[k*DATA_W +: DATA_W];
            assign w_elig[k]      = i_req_valid[k] & (i_req_we[k] | w_rd_room);
        end
    endgenerate

    assign w_rd_room = (r_count < CNT_W'(MAX_OUT));

    // Search upward from the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IW1'(i);
            if (w_idx >= IW1'(NUM_REQ)) begin
                w_idx = w_idx - IW1'(NUM_REQ);
            end
            if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_rr_next  = (r_win_id == ID_W'(NUM_REQ - 1)) ? '0 : r_win_id + 1'b1;
    assign w_accept   = (r_state == ST_ISSUE) && i_ctrl_ready;
    assign w_push     = w_accept && !r_ctrl_we;
    assign w_pop      = i_ctrl_rd_valid && (r_count != '0);
    assign w_spurious = i_ctrl_rd_valid && (r_count == '0);

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_rst) begin
            r_state      <= ST_ARB;
            r_rr_ptr     <= '0;
            r_win_id     <= '0;
            r_ctrl_valid <= 1'b0;
            r_ctrl_we    <= 1'b0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
            r_req_ready  <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_win_id     <= w_win;
                        r_ctrl_valid <= 1'b1;
                        r_ctrl_we    <= i_req_we[w_win];
                        r_ctrl_addr  <= w_addr_arr[w_win];
                        r_ctrl_wdata <= w_wdata_arr[w_win];
                        r_req_ready  <= NUM_REQ'(1) << w_win;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_req_ready  <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_req_ready <= '0;
                    if (i_ctrl_ready) begin
                        r_ctrl_valid <= 1'b0;
                        r_rr_ptr     <= w_rr_next;
                        r_state      <= ST_ARB;
                    end
                end
                default: begin
                    r_req_ready <= '0;
                    r_state     <= ST_ARB;
                end
            endcase
        end
    end

    // ID FIFO: a push and pop on the same edge leave the count unchanged.
    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_cpu_ck) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_win_id;
        end
    end

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_valid <= NUM_REQ'(1) << r_fifo[r_rptr];
                r_rd_data  <= i_ctrl_rd_data;
            end else begin
                r_rd_valid <= '0;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    a_count_le_max: assert property (@(posedge i_cpu_ck) disable iff (i_cpu_rst)
        r_count <= CNT_W'(MAX_OUT));

    assign o_req_ready   = r_req_ready;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_ctrl_valid  = r_ctrl_valid;
    assign o_ctrl_we     = r_ctrl_we;
    assign o_ctrl_addr   = r_ctrl_addr;
    assign o_ctrl_wdata  = r_ctrl_wdata;
    assign o_outstanding = r_count;
    assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_port_arbiter
// Purpose  : Scoreboard bench for ddr3_port_arbiter (grants and read returns).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 27;
    localparam int DW = 64;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rd_valid_o;
    logic [DW-1:0]   rd_data_o;
    logic            ctrl_valid;
    logic            ctrl_we;
    logic [AW-1:0]   ctrl_addr;
    logic [DW-1:0]   ctrl_wdata;
    logic            ctrl_ready;
    logic            ctrl_rd_valid;
    logic [DW-1:0]   ctrl_rd_data;
    logic [2:0]      outstanding;
    logic            err;

    typedef struct {
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    grant_t        q_grant [$];
    rd_t           q_rd    [$];
    logic          a_we    [NR];
    logic [AW-1:0] a_addr  [NR];
    logic [DW-1:0] a_wdata [NR];
    logic [NR-1:0] keep;
    int            n_checks;
    int            n_fail;

    ddr3_port_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_OUT (4)
    ) u_dut (
        .i_cpu_ck        (clk),
        .i_cpu_rst       (rst),
        .i_req_valid     (req_valid),
        .i_req_we        (req_we),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_req_ready     (req_ready),
        .o_rd_valid      (rd_valid_o),
        .o_rd_data       (rd_data_o),
        .o_ctrl_valid    (ctrl_valid),
        .o_ctrl_we       (ctrl_we),
        .o_ctrl_addr     (ctrl_addr),
        .o_ctrl_wdata    (ctrl_wdata),
        .i_ctrl_ready    (ctrl_ready),
        .i_ctrl_rd_valid (ctrl_rd_valid),
        .i_ctrl_rd_data  (ctrl_rd_data),
        .o_outstanding   (outstanding),
        .o_err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: advance past the edge, then score any grant or read return.
    task automatic cyc();
        grant_t g;
        rd_t    r;
        @(posedge clk);
        #1;
        if (req_ready != '0) begin
            if (q_grant.size() == 0) begin
                chk("unexpected_grant", 64'(req_ready), 64'd0);
            end else begin
                g = q_grant.pop_front();
                chk("grant_onehot", 64'(req_ready), 64'd1 << g.id);
                chk("grant_valid", 64'(ctrl_valid), 64'd1);
                chk("grant_we", 64'(ctrl_we), 64'(g.we));
                chk("grant_addr", 64'(ctrl_addr), 64'(g.addr));
                chk("grant_wdata", ctrl_wdata, g.wdata);
            end
            req_valid = req_valid & ~(req_ready & ~keep);
        end
        if (rd_valid_o != '0) begin
            if (q_rd.size() == 0) begin
                chk("unexpected_rd_valid", 64'(rd_valid_o), 64'd0);
            end else begin
                r = q_rd.pop_front();
                chk("rd_onehot", 64'(rd_valid_o), 64'd1 << r.id);
                chk("rd_data", rd_data_o, r.data);
            end
        end
    endtask

    task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        a_we[k]    = we;
        a_addr[k]  = addr;
        a_wdata[k] = wdata;
        req_we[k]  = we;
        req_addr[k*AW +: AW]  = addr;
        req_wdata[k*DW +: DW] = wdata;
        req_valid[k] = 1'b1;
    endtask

    task automatic expect_grant(input int k);
        grant_t g;
        g.id    = k;
        g.we    = a_we[k];
        g.addr  = a_addr[k];
        g.wdata = a_wdata[k];
        q_grant.push_back(g);
    endtask

    task automatic expect_rd(input int k, input logic [DW-1:0] d);
        rd_t r;
        r.id   = k;
        r.data = d;
        q_rd.push_back(r);
    endtask

    task automatic wait_grant(input int k);
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (req_ready[k]) return;
        end
        chk("grant_timeout", 64'(req_ready[k]), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic ret(input int k, input logic [DW-1:0] d);
        expect_rd(k, d);
        ctrl_rd_valid = 1'b1;
        ctrl_rd_data  = d;
        cyc();
        ctrl_rd_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        keep = '0;
        ctrl_ready = 1'b1;
        ctrl_rd_valid = 1'b0;
        ctrl_rd_data = '0;
        for (int k = 0; k < NR; k++) begin
            a_we[k] = 1'b0;
            a_addr[k] = '0;
            a_wdata[k] = '0;
        end
        do_reset();

        chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_rd_data", rd_data_o, 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Single uncontended write: granted on the first edge.
        issue(2, 1'b1, 27'h100, 64'hA5A5);
        expect_grant(2);
        cyc();
        chk("single_latency", 64'(req_ready), 64'b0100);
        cyc();
        chk("single_valid_drop", 64'(ctrl_valid), 64'd0);
        chk("single_outstanding", 64'(outstanding), 64'd0);

        // Round-robin: all four writing continuously.
        do_reset();
        for (int k = 0; k < NR; k++) issue(k, 1'b1, 27'(32'h10 * (k + 1)), 64'(32'hC0DE_0000 + k));
        keep = 4'hF;
        for (int j = 0; j < 2; j++) for (int k = 0; k < NR; k++) expect_grant(k);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("rr_spacing", 64'(req_ready != '0), 64'((i % 2) == 0));
        end
        req_valid = '0;
        keep = '0;
        chk("rr_all_granted", 64'(q_grant.size()), 64'd0);

        // Backpressure: controller stalls five cycles.
        ctrl_ready = 1'b0;
        issue(1, 1'b1, 27'h200, 64'h1111);
        issue(2, 1'b1, 27'h300, 64'h2222);
        expect_grant(1);
        expect_grant(2);
        wait_grant(1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", 64'(ctrl_valid), 64'd1);
            chk("bp_addr", 64'(ctrl_addr), 64'h200);
            chk("bp_wdata", ctrl_wdata, 64'h1111);
            chk("bp_no_grant", 64'(req_ready), 64'd0);
        end
        ctrl_ready = 1'b1;
        cyc();
        chk("bp_accept", 64'(ctrl_valid), 64'd0);
        cyc();
        chk("bp_next_grant", 64'(req_ready), 64'b0100);
        cyc();

        // Outstanding limit: four reads fill the ID FIFO.
        for (int n = 0; n < 4; n++) begin
            issue(1, 1'b0, 27'(32'hA0 + n), 64'd0);
            expect_grant(1);
            wait_grant(1);
            cyc();
            chk("out_fill", 64'(outstanding), 64'(n + 1));
        end
        issue(1, 1'b0, 27'hA4, 64'd0);
        issue(3, 1'b1, 27'h333, 64'h3333);
        expect_grant(3);
        wait_grant(3);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("out_full_hold", 64'(outstanding), 64'd4);
        end
        expect_grant(1);
        ret(1, 64'hD000_0001);
        chk("out_after_ret", 64'(outstanding), 64'd3);
        wait_grant(1);
        cyc();
        chk("out_refill", 64'(outstanding), 64'd4);
        for (int n = 0; n < 4; n++) ret(1, 64'(32'hE000_0000 + n));
        chk("out_drained", 64'(outstanding), 64'd0);

        // Return routing for reads from 3, 0, 3.
        issue(3, 1'b0, 27'h30, 64'd0); expect_grant(3); wait_grant(3); cyc();
        issue(0, 1'b0, 27'h31, 64'd0); expect_grant(0); wait_grant(0); cyc();
        issue(3, 1'b0, 27'h32, 64'd0); expect_grant(3); wait_grant(3); cyc();
        chk("route_out3", 64'(outstanding), 64'd3);
        ret(3, 64'hD0D0_0000);
        ret(0, 64'hD1D1_1111);
        ret(3, 64'hD2D2_2222);
        chk("route_out0", 64'(outstanding), 64'd0);

        // Push and pop on the same edge.
        issue(0, 1'b0, 27'h40, 64'd0); expect_grant(0); wait_grant(0); cyc();
        issue(2, 1'b0, 27'h41, 64'd0); expect_grant(2); wait_grant(2);
        ret(0, 64'h5555_AAAA);
        chk("pushpop_count", 64'(outstanding), 64'd1);
        ret(2, 64'hAAAA_5555);
        chk("pushpop_drain", 64'(outstanding), 64'd0);
        chk("err_clear_before", 64'(err), 64'd0);

        // Spurious return sets the sticky error.
        ctrl_rd_valid = 1'b1;
        ctrl_rd_data  = 64'hDEAD;
        cyc();
        ctrl_rd_valid = 1'b0;
        chk("spur_err", 64'(err), 64'd1);
        chk("spur_no_rd", 64'(rd_valid_o), 64'd0);
        cyc();
        chk("spur_sticky", 64'(err), 64'd1);

        // Reset while a command is held in ISSUE.
        issue(1, 1'b0, 27'h50, 64'd0); expect_grant(1); wait_grant(1); cyc();
        ctrl_ready = 1'b0;
        issue(2, 1'b1, 27'h222, 64'h2222_2222);
        expect_grant(2);
        wait_grant(2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid_valid", 64'(ctrl_valid), 64'd0);
        chk("rstmid_out", 64'(outstanding), 64'd0);
        chk("rstmid_err", 64'(err), 64'd0);
        chk("rstmid_rd_data", rd_data_o, 64'd0);
        ctrl_ready = 1'b1;
        issue(3, 1'b1, 27'h63, 64'h63);
        issue(0, 1'b1, 27'h60, 64'h60);
        expect_grant(0);
        expect_grant(3);
        wait_grant(0);
        cyc();
        wait_grant(3);
        cyc();
        cyc();

        chk("grant_queue_empty", 64'(q_grant.size()), 64'd0);
        chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
